// File: rtl/galvo_dac_scheduler.sv
// Point scheduler for a dual 12-bit SPI galvo DAC: serialises X then Y, latches both, then dwells.
// Optional BLANK_ON_MOVE_EN blanks the laser from accept until the latch of the new point.
module galvo_dac_scheduler #(
    parameter int SCLK_DIV     = 4,
    parameter int CS_GAP       = 2,
    parameter int DWELL_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        point_valid,
    output logic        point_ready,
    input  logic [11:0] point_x,
    input  logic [11:0] point_y,
    input  logic [2:0]  point_rgb,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        dac_csn,
    output logic        dac_latchn,
    output logic [2:0]  laser_rgb,
    output logic        frame_done
);

    localparam int PW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int DW = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;

    localparam logic [PW-1:0] PHASE_LAST = PW'(SCLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(CS_GAP - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'((DWELL_CYCLES > 0) ? (DWELL_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT_X = 3'd1,
        ST_GAP     = 3'd2,
        ST_SHIFT_Y = 3'd3,
        ST_LATCH   = 3'd4,
        ST_DWELL   = 3'd5
    } state_t;

    // DAC command word: channel, unbuffered, gain 1x, active, 12-bit code
    function automatic logic [15:0] dac_word(input logic ch, input logic [11:0] data);
        return {ch, 1'b0, 1'b1, 1'b1, data};
    endfunction

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          half_q, half_d;
    logic [3:0]    bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [15:0]   shreg_q, shreg_d;
    logic [11:0]   y_q, y_d;
    logic [2:0]    rgb_q, rgb_d;

    logic          csn_q, csn_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          latchn_q, latchn_d;
    logic [2:0]    laser_q, laser_d;
    logic          done_q, done_d;

    logic          accept_s;
    logic          shift_s;

    assign point_ready = (state_q == ST_IDLE) && !reset;
    assign accept_s    = point_valid && point_ready;

    // Next-state and counter sequencing
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        half_d  = half_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        dwell_d = dwell_q;
        shreg_d = shreg_q;
        y_d     = y_q;
        rgb_d   = rgb_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SHIFT_X;
                    phase_d = '0;
                    half_d  = 1'b0;
                    bit_d   = 4'd0;
                    shreg_d = dac_word(1'b0, point_x);
                    y_d     = point_y;
                    rgb_d   = point_rgb;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT_X, ST_SHIFT_Y: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            if (state_q == ST_SHIFT_X) begin
                                state_d = ST_GAP;
                                gap_d   = '0;
                            end else begin
                                state_d = ST_LATCH;
                            end
                        end else begin
                            // Next bit presented on the first low cycle of its slot
                            bit_d   = bit_q + 4'd1;
                            shreg_d = {shreg_q[14:0], 1'b0};
                        end
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_SHIFT_Y;
                    phase_d = '0;
                    half_d  = 1'b0;
                    bit_d   = 4'd0;
                    shreg_d = dac_word(1'b1, y_q);
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_LATCH: begin
                if (phase_q == PHASE_LAST) begin
                    if (DWELL_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DWELL;
                        dwell_d = '0;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_DWELL: begin
                if (dwell_q == DWELL_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every pin comes straight from a flop
    always_comb begin
        shift_s  = (state_d == ST_SHIFT_X) || (state_d == ST_SHIFT_Y);
        csn_d    = !shift_s;
        sclk_d   = shift_s && half_d;
        mosi_d   = shift_s ? shreg_d[15] : 1'b0;
        latchn_d = (state_d != ST_LATCH);
        laser_d  = laser_q;
        if ((state_d == ST_LATCH) && (state_q != ST_LATCH)) begin
            laser_d = rgb_q;
        end else begin
`ifdef BLANK_ON_MOVE_EN
            if (accept_s) begin
                laser_d = 3'b000;
            end else begin
                laser_d = laser_q;
            end
`else
            laser_d = laser_q;
`endif
        end
        if (DWELL_CYCLES == 0) begin
            done_d = (state_d == ST_LATCH) && (phase_d == PHASE_LAST);
        end else begin
            done_d = (state_d == ST_DWELL) && (dwell_d == DWELL_LAST);
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            half_q   <= 1'b0;
            bit_q    <= 4'd0;
            gap_q    <= '0;
            dwell_q  <= '0;
            shreg_q  <= 16'h0000;
            y_q      <= 12'h000;
            rgb_q    <= 3'b000;
            csn_q    <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            latchn_q <= 1'b1;
            laser_q  <= 3'b000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            dwell_q  <= dwell_d;
            shreg_q  <= shreg_d;
            y_q      <= y_d;
            rgb_q    <= rgb_d;
            csn_q    <= csn_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            latchn_q <= latchn_d;
            laser_q  <= laser_d;
            done_q   <= done_d;
        end
    end

    assign dac_csn    = csn_q;
    assign dac_sclk   = sclk_q;
    assign dac_mosi   = mosi_q;
    assign dac_latchn = latchn_q;
    assign laser_rgb  = laser_q;
    assign frame_done = done_q;

endmodule
